// File: rtl/lfsr_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Brief    : Locks onto an 8-bit maximal-length LFSR word stream, flywheels
//            through errors while locked, and counts mismatches.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        clear_count,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [1:0] c_hunt     = 2'd0;
    localparam logic [1:0] c_verify   = 2'd1;
    localparam logic [1:0] c_locked   = 2'd2;
    localparam logic [3:0] c_lock_cnt = 4'(LOCK_COUNT);
    localparam logic [3:0] c_loss_cnt = 4'(LOSS_COUNT);

    logic [1:0]  r_state;
    logic [7:0]  r_expected;
    logic [3:0]  r_cnt;
    logic        r_locked;
    logic        r_err_pulse;
    logic [15:0] r_err_count;

    logic [1:0]  w_state_next;
    logic [7:0]  w_expected_next;
    logic [3:0]  w_cnt_next;
    logic [3:0]  w_cnt_inc;
    logic        w_match;
    logic        w_err;
    logic [15:0] w_err_count_next;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign w_match   = (in_data == r_expected);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_next    = r_state;
        w_expected_next = r_expected;
        w_cnt_next      = r_cnt;
        w_err           = 1'b0;
        if (in_valid) begin
            case (r_state)
                c_hunt: begin
                    if (in_data != 8'h00) begin
                        w_expected_next = lfsr_next(in_data);
                        w_cnt_next      = 4'd0;
                        w_state_next    = c_verify;
                    end
                end
                c_verify: begin
                    if (w_match) begin
                        w_expected_next = lfsr_next(r_expected);
                        if (w_cnt_inc == c_lock_cnt) begin
                            w_state_next = c_locked;
                            w_cnt_next   = 4'd0;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end else if (in_data != 8'h00) begin
                        w_expected_next = lfsr_next(in_data);
                        w_cnt_next      = 4'd0;
                    end else begin
                        w_state_next = c_hunt;
                        w_cnt_next   = 4'd0;
                    end
                end
                c_locked: begin
                    // Flywheel: the data never reseeds the generator once locked.
                    w_expected_next = lfsr_next(r_expected);
                    if (w_match) begin
                        w_cnt_next = 4'd0;
                    end else begin
                        w_err = 1'b1;
                        if (w_cnt_inc == c_loss_cnt) begin
                            w_state_next = c_hunt;
                            w_cnt_next   = 4'd0;
                        end else begin
                            w_cnt_next   = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_next = c_hunt;
                    w_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_err_count_next = r_err_count;
        if (clear_count) begin
            w_err_count_next = 16'h0000;
        end else if (w_err && (r_err_count != 16'hFFFF)) begin
            w_err_count_next = r_err_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_hunt;
            r_expected  <= 8'h00;
            r_cnt       <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'h0000;
        end else begin
            r_state     <= w_state_next;
            r_expected  <= w_expected_next;
            r_cnt       <= w_cnt_next;
            r_locked    <= (w_state_next == c_locked);
            r_err_pulse <= w_err;
            r_err_count <= w_err_count_next;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The module SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive matching words needed to declare lock (legal range 1..15).
REQ-002 The module SHALL have parameter LOSS_COUNT, default 3, meaning the number of consecutive mismatching words while locked that drop lock (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_data, input, 8 bits: the received sequence word.
REQ-006 The module SHALL have port in_valid, input, 1 bit: in_data is sampled only when high; there is no backpressure.
REQ-007 The module SHALL have port clear_count, input, 1 bit: synchronously zeroes err_count.
REQ-008 The module SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-009 The module SHALL have port err_pulse, output, 1 bit: one-cycle strobe per mismatch detected in LOCKED.
REQ-010 The module SHALL have port err_count, output, 16 bits: saturating count of LOCKED mismatches.

Function
REQ-011 The sequence relation SHALL be next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}, a maximal-length 255-state sequence; 0x00 is never a legal word.
REQ-012 The block SHALL hold an expected register, a 4-bit match/miss counter and a 3-state FSM: HUNT, VERIFY, LOCKED.
REQ-013 All outputs SHALL be registered and SHALL reflect a sampled word on the cycle after its in_valid cycle; cycles with in_valid low SHALL change no state.
REQ-014 In HUNT, a valid non-zero word SHALL load expected = next(word), clear the counter and move to VERIFY; a valid 0x00 SHALL be ignored.
REQ-015 In VERIFY, a valid word equal to expected SHALL increment the counter and advance expected = next(expected); when the counter reaches LOCK_COUNT the FSM SHALL enter LOCKED and clear the counter.
REQ-016 In VERIFY, a mismatching non-zero word SHALL reseed: expected = next(word), counter = 0, stay in VERIFY; a mismatching 0x00 SHALL return the FSM to HUNT.
REQ-017 In LOCKED, every valid word SHALL advance expected = next(expected), whether or not it matches (flywheel; no reseed from data).
REQ-018 In LOCKED, a match SHALL clear the miss counter; a mismatch SHALL assert err_pulse for one cycle, increment err_count and increment the miss counter.
REQ-019 When the miss counter reaches LOSS_COUNT, the FSM SHALL enter HUNT and locked SHALL fall on the same cycle that err_pulse reports that mismatch.
REQ-020 err_count SHALL saturate at 0xFFFF and never wrap.
REQ-021 When clear_count coincides with an err_pulse-producing mismatch, clear SHALL take priority and err_count SHALL be 0 the next cycle; err_pulse SHALL still assert.
REQ-022 err_pulse and err_count SHALL never change outside LOCKED.

Reset
REQ-023 When reset is high at a clock edge, the FSM SHALL be set to HUNT, expected to 0x00, counter to 0, locked to 0, err_pulse to 0 and err_count to 0.
REQ-024 reset SHALL take priority over in_valid and clear_count, including mid-VERIFY or mid-LOCKED; the word sampled on a reset cycle SHALL be discarded.

Verification
REQ-025 Lock: after reset, stream 8A,14,29,52,A5 with in_valid high -> locked rises the cycle after A5 is sampled; err_count = 0.
REQ-026 Single error: once locked, send 4A, then 00 in place of 95, then 2A -> one err_pulse, err_count = 1, locked stays 1, and 2A still matches because of the flywheel.
REQ-027 Loss: once locked, send three consecutive wrong words -> err_pulse on each, err_count = 3, locked falls with the third pulse, and the FSM is in HUNT.
REQ-028 Reseed: in VERIFY after 8A,14, send 52 instead of 29, then A5,4A,95,2A -> no lock until 2A, the fourth match after reseed on 52.
REQ-029 Gaps and priority: the REQ-025 stream with random in_valid gaps locks identically; an error with simultaneous clear_count -> err_pulse = 1 and err_count = 0; reset asserted mid-LOCKED -> all outputs 0 the next cycle.
REQ-030 Saturation: preload the count to 0xFFFE (force or long run), then inject 3 errors while relocking -> err_count holds at 0xFFFF.
